// File: rtl/reg_file_pkg.sv
// Shared pipeline constants for the register file: widths, register count
// and the index of the hardwired zero register.
package reg_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int REG_ZERO = 0;
    localparam int WCNT_W   = 16;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports with WB->ID bypass,
// one write port, r0 hardwired to zero, and a committed-write debug counter.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWriteIn,
    input  logic [ADDR_W-1:0] WriteRegIn,
    input  logic [DATA_W-1:0] WriteDataIn,
    input  logic [ADDR_W-1:0] ReadReg1In,
    input  logic [ADDR_W-1:0] ReadReg2In,
    output logic [DATA_W-1:0] ReadData1Out,
    output logic [DATA_W-1:0] ReadData2Out,
    output logic [WCNT_W-1:0] WriteCountOut
);

    localparam int               NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [WCNT_W-1:0] write_count_q;
    logic [WCNT_W-1:0] write_count_d;
    logic              wr_commit;

    // A write only takes effect outside reset and never targets r0.
    assign wr_commit = !Reset && RegWriteIn && (WriteRegIn != ZERO_IDX);

    function automatic logic bypass_hit(input logic                commit,
                                        input logic [ADDR_W-1:0] wr_idx,
                                        input logic [ADDR_W-1:0] rd_idx);
        return commit && (wr_idx == rd_idx);
    endfunction

    always_comb begin
        regs_d        = regs_q;
        write_count_d = write_count_q;
        if (wr_commit) begin
            regs_d[WriteRegIn] = WriteDataIn;
            write_count_d      = write_count_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            write_count_q <= '0;
        end else begin
            regs_q        <= regs_d;
            write_count_q <= write_count_d;
        end
    end

    // r0 is forced to zero on read as well, so it never shows bypassed data.
    always_comb begin
        ReadData1Out = '0;
        ReadData2Out = '0;
        if (!Reset && (ReadReg1In != ZERO_IDX)) begin
            ReadData1Out = bypass_hit(wr_commit, WriteRegIn, ReadReg1In) ? WriteDataIn
                                                                          : regs_q[ReadReg1In];
        end
        if (!Reset && (ReadReg2In != ZERO_IDX)) begin
            ReadData2Out = bypass_hit(wr_commit, WriteRegIn, ReadReg2In) ? WriteDataIn
                                                                          : regs_q[ReadReg2In];
        end
    end

    assign WriteCountOut = write_count_q;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a reference model predicts read data and
// the write counter, expectations queue up when a cycle is driven.
module tb_reg_file;

    logic        Clk;
    logic        Reset;
    logic        RegWriteIn;
    logic [4:0]  WriteRegIn;
    logic [31:0] WriteDataIn;
    logic [4:0]  ReadReg1In;
    logic [4:0]  ReadReg2In;
    logic [31:0] ReadData1Out;
    logic [31:0] ReadData2Out;
    logic [15:0] WriteCountOut;

    logic [31:0] exp_q[$];
    logic [31:0] m_regs [32];
    logic [15:0] m_count;
    int          n_checks;
    int          n_fail;

    reg_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .RegWriteIn   (RegWriteIn),
        .WriteRegIn   (WriteRegIn),
        .WriteDataIn  (WriteDataIn),
        .ReadReg1In   (ReadReg1In),
        .ReadReg2In   (ReadReg2In),
        .ReadData1Out (ReadData1Out),
        .ReadData2Out (ReadData2Out),
        .WriteCountOut(WriteCountOut)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic rst, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd,
                                               input logic [4:0] ra);
        if (rst || ra == 5'd0) return 32'h0;
        if (we && wa == ra)    return wd;
        return m_regs[ra];
    endfunction

    // Drive one cycle, queue expectations, compare mid-cycle, advance model at the edge.
    task automatic step(input logic rst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                        input string tag);
        Reset       = rst;
        RegWriteIn  = we;
        WriteRegIn  = wa;
        WriteDataIn = wd;
        ReadReg1In  = ra1;
        ReadReg2In  = ra2;
        exp_q.push_back(model_read(rst, we, wa, wd, ra1));
        exp_q.push_back(model_read(rst, we, wa, wd, ra2));
        exp_q.push_back({16'h0, m_count});
        @(negedge Clk);
        check_eq({tag, "_rd1"}, ReadData1Out, exp_q.pop_front());
        check_eq({tag, "_rd2"}, ReadData2Out, exp_q.pop_front());
        check_eq({tag, "_wcnt"}, {16'h0, WriteCountOut}, exp_q.pop_front());
        @(posedge Clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_count = 16'h0;
        end else if (we && wa != 5'd0) begin
            m_regs[wa] = wd;
            m_count    = m_count + 16'h1;
        end
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_count  = 16'h0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        Reset       = 1'b1;
        RegWriteIn  = 1'b0;
        WriteRegIn  = 5'd0;
        WriteDataIn = 32'h0;
        ReadReg1In  = 5'd0;
        ReadReg2In  = 5'd0;
        @(posedge Clk);
        #1;

        // reset held: outputs zero even with a write and nonzero indices
        step(1'b1, 1'b1, 5'd7, 32'hCAFE_F00D, 5'd7, 5'd7, "rst_hold");

        // write r8, read it back next cycle
        step(1'b0, 1'b1, 5'd8, 32'h1234_5678, 5'd1, 5'd2, "wr_r8");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0, "rd_r8");

        // same-cycle bypass on both ports, then the stored value
        step(1'b0, 1'b1, 5'd9, 32'hDEAD_BEEF, 5'd9, 5'd9, "byp_r9");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd8, "rd_r9");

        // r0 never written, never bypassed
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "wr_r0");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "rd_r0");

        // disabled write: old value visible, no bypass, no update
        step(1'b0, 1'b1, 5'd3, 32'h5555_0003, 5'd0, 5'd0, "wr_r3");
        step(1'b0, 1'b0, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd3, "nowr_r3");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd9, "rd_r3");

        // fill r1..r31, then reset concurrent with a write to r5
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'(i * 32'h11), 5'(i - 1), 5'($urandom_range(0, 31)), "fill");
        end
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31, "fill_rd");
        step(1'b1, 1'b1, 5'd5, 32'h0BAD_0005, 5'd5, 5'd31, "rst_wr");
        for (int i = 0; i < 32; i += 2) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), "post_rst");
        end

        // random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "rand");
        end

        // counter wrap: 65537 committed writes from a clean reset
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "wrap_rst");
        for (int i = 0; i < 65537; i++) begin
            step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "wrap");
        end
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, "wrap_end");
        check_eq("wrap_count", {16'h0, WriteCountOut}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter DATA_W, 32, register and port data width.
REQ-002 Parameter ADDR_W, 5, register index width (2**ADDR_W = 32 registers).
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-005 RegWriteIn  input  1  write enable from MAWB stage.
REQ-006 WriteRegIn  input  ADDR_W  destination register index from MAWB.
REQ-007 WriteDataIn  input  DATA_W  writeback data from the writeback data selector.
REQ-008 ReadReg1In  input  ADDR_W  rs index from decode stage.
REQ-009 ReadReg2In  input  ADDR_W  rt index from decode stage.
REQ-010 ReadData1Out  output  DATA_W  data for ReadReg1In.
REQ-011 ReadData2Out  output  DATA_W  data for ReadReg2In.
REQ-012 WriteCountOut  output  16  count of committed writes since reset, for debug.

Function
REQ-013 Storage: 32 registers of DATA_W bits; register 0 hardwired to zero, never written.
REQ-014 Write: on rising edge with Reset=0, RegWriteIn=1, WriteRegIn!=0 -> reg[WriteRegIn] <= WriteDataIn; 1-cycle latency.
REQ-015 Write with WriteRegIn=0 or RegWriteIn=0: no state change, WriteCountOut unchanged.
REQ-016 Read ports combinational (0-cycle latency) from array, independent of each other.
REQ-017 Bypass: if Reset=0, RegWriteIn=1, WriteRegIn!=0, WriteRegIn==ReadRegNIn -> ReadDataNOut = WriteDataIn same cycle (write-before-read, no stall across WB/ID).
REQ-018 ReadRegNIn=0 -> ReadDataNOut = 0 regardless of write/bypass state.
REQ-019 Both read ports addressing same register as write -> both bypassed identically.
REQ-020 While Reset=1: ReadData1Out = ReadData2Out = 0, bypass disabled, writes ignored.
REQ-021 WriteCountOut increments by 1 per committed write (REQ-014 only); wraps 0xFFFF -> 0x0000.
REQ-022 No X propagation: all outputs defined for any in-range index once reset has been applied.

Reset
REQ-023 Reset=1 at rising edge -> all 32 registers <= 0, WriteCountOut <= 0.
REQ-024 Reset has priority over a simultaneous write; the write is dropped and not counted.
REQ-025 Reset mid-program (any cycle) -> identical result to power-on reset; no state retained.

Structure
REQ-026 DATA_W, ADDR_W, register-count constant, and the index constant REG_ZERO = 0 live in the shared pipeline package.
REQ-027 Single module, no sub-modules; bypass compare logic is one function reused for both read ports.
REQ-028 Storage is a flat register array in the module (no memory macro); reset loop clears every entry.

Verification
REQ-029 Reset; write 0x1234_5678 to r8; next cycle read r8 on port 1 -> ReadData1Out = 0x1234_5678, WriteCountOut = 1.
REQ-030 Same-cycle write 0xDEAD_BEEF to r9 with ReadReg1In = ReadReg2In = 9 -> both outputs 0xDEAD_BEEF in that cycle (bypass).
REQ-031 Write 0xFFFF_FFFF to r0 -> read r0 on both ports = 0 in same and next cycle; WriteCountOut unchanged.
REQ-032 Fill r1..r31 with index*0x11, assert Reset one cycle concurrent with a write to r5 -> all reads 0 afterwards, WriteCountOut = 0.
REQ-033 RegWriteIn=0 with WriteRegIn=3, WriteDataIn=0xAAAA_AAAA, ReadReg1In=3 -> ReadData1Out shows old r3 value, no bypass, no update.
REQ-034 Issue 65537 committed writes -> WriteCountOut = 1 (wrap check).
